// File: rtl/image_stream_pkg.sv
// Shared types and sizing helpers for the image stream line-window blocks.
package image_stream_pkg;

   localparam int PIX_W_DEF       = 32'd8;
   typedef logic [PIX_W_DEF-1:0] pixel_t;

   // Slice 0 is the live pixel; slices from 1 upward come from the line RAM chain.
   localparam int SLICE_CUR       = 32'd0;
   localparam int SLICE_FIRST_RAM = 32'd1;

   function automatic int col_addr_w(input int max_cols);
      return (max_cols > 32'd1) ? $clog2(max_cols) : 32'd1;
   endfunction

   function automatic int slice_lsb(input int k, input int width);
      return k * width;
   endfunction

endpackage

// File: rtl/image_line_ram.sv
// One line of pixel storage: simple dual-port, registered read, read-before-write.
module image_line_ram
   import image_stream_pkg::*;
#(
   parameter int Pra_Width  = 8,
   parameter int Pra_Depth  = 1024,
   parameter int Pra_Addr_W = col_addr_w(Pra_Depth)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [Pra_Addr_W-1:0] waddr,
   input  logic [Pra_Width-1:0]  wdata,
   input  logic                  re,
   input  logic [Pra_Addr_W-1:0] raddr,
   output logic [Pra_Width-1:0]  rdata
);

   logic [Pra_Width-1:0] mem_r [Pra_Depth];
   logic [Pra_Width-1:0] rdata_r;

   // Read and write share the edge, so a same-address read returns the old word.
   always_ff @(posedge clk) begin
      if (re) rdata_r <= mem_r[raddr];
      if (we) mem_r[waddr] <= wdata;
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/image_line_window.sv
// Turns one pixel stream into a vertical column of Pra_Rows pixels (current line
// plus the lines above), with frame-sync gating, top-edge masking and overflow flag.
module image_line_window
   import image_stream_pkg::*;
#(
   parameter int Pra_Width    = 8,
   parameter int Pra_Rows     = 7,
   parameter int Pra_Max_Cols = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_vs,
   input  logic                          in_hs,
   input  logic                          in_en,
   input  logic [Pra_Width-1:0]          in_data,
   output logic                          out_vs,
   output logic                          out_hs,
   output logic                          out_en,
   output logic [Pra_Rows*Pra_Width-1:0] out_data,
   output logic                          out_full,
   output logic                          err_overflow
);

   localparam int AW = col_addr_w(Pra_Max_Cols);
   localparam int CW = AW + 1;
   localparam int LW = $clog2(Pra_Rows);
   localparam int NR = Pra_Rows - 1;
   localparam logic [CW-1:0] MAX_COL   = CW'(Pra_Max_Cols);
   localparam logic [CW-1:0] COL_ONE   = CW'(32'd1);
   localparam logic [LW-1:0] LAST_LINE = LW'(NR);
   localparam logic [LW-1:0] LINE_ONE  = LW'(32'd1);

   typedef logic [Pra_Width-1:0] pix_t;

   logic          vs_r, hs_r, en_r, sync_ok_r, err_r, out_en_r, out_full_r, wr_en_r;
   logic [CW-1:0] col_cnt_r;
   logic [LW-1:0] line_cnt_r, line_q_r;
   logic [AW-1:0] wr_addr_r;
   pix_t          data_r;

   logic          vs_rise_s, hs_rise_s, sync_s, room_s, accept_s, ovf_s, en_fall_s;
   logic [CW-1:0] col_s;
   logic [LW-1:0] line_s;
   pix_t          ram_rd_s [NR];
   pix_t          ram_wd_s [NR];
   logic [Pra_Rows*Pra_Width-1:0] out_data_s;

   // Decode sync edges and the effective column/line for the pixel on the input.
   always_comb begin
      vs_rise_s = in_vs & ~vs_r;
      hs_rise_s = in_hs & ~hs_r;
      sync_s    = sync_ok_r | vs_rise_s;
      en_fall_s = en_r & ~in_en & sync_ok_r;
      if (vs_rise_s | hs_rise_s) begin
         col_s = '0;
      end else begin
         col_s = col_cnt_r;
      end
      if (vs_rise_s) begin
         line_s = '0;
      end else begin
         line_s = line_cnt_r;
      end
      room_s   = (col_s < MAX_COL);
      accept_s = in_en & sync_s & room_s & ~rst;
      ovf_s    = in_en & sync_s & ~room_s;
   end

   // Counters, sync state and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_r       <= 1'b0;
         hs_r       <= 1'b0;
         en_r       <= 1'b0;
         sync_ok_r  <= 1'b0;
         col_cnt_r  <= '0;
         line_cnt_r <= '0;
         err_r      <= 1'b0;
         out_en_r   <= 1'b0;
         out_full_r <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= '0;
         data_r     <= '0;
         line_q_r   <= '0;
      end else begin
         vs_r      <= in_vs;
         hs_r      <= in_hs;
         en_r      <= in_en;
         sync_ok_r <= sync_s;
         col_cnt_r <= accept_s ? (col_s + COL_ONE) : col_s;
         if (vs_rise_s) begin
            line_cnt_r <= '0;
         end else if (en_fall_s && (line_cnt_r != LAST_LINE)) begin
            line_cnt_r <= line_cnt_r + LINE_ONE;
         end
         err_r      <= vs_rise_s ? 1'b0 : (err_r | ovf_s);
         out_en_r   <= accept_s;
         out_full_r <= accept_s & (line_s == LAST_LINE);
         wr_en_r    <= accept_s;
         if (accept_s) begin
            data_r    <= in_data;
            line_q_r  <= line_s;
            wr_addr_r <= col_s[AW-1:0];
         end
      end
   end

   // RAM j is written one cycle after the read, with what RAM j-1 held at that column.
   for (genvar j = 0; j < NR; j++) begin : g_ram
      if (j == 0) begin : g_head
         assign ram_wd_s[j] = data_r;
      end else begin : g_tail
         assign ram_wd_s[j] = ram_rd_s[j-1];
      end
      image_line_ram #(
         .Pra_Width  (Pra_Width),
         .Pra_Depth  (Pra_Max_Cols),
         .Pra_Addr_W (AW)
      ) u_ram (
         .clk   (clk),
         .we    (wr_en_r),
         .waddr (wr_addr_r),
         .wdata (ram_wd_s[j]),
         .re    (accept_s),
         .raddr (col_s[AW-1:0]),
         .rdata (ram_rd_s[j])
      );
   end

   // Top-edge mask: hide slices reaching above the first line of the frame.
   always_comb begin
      out_data_s = '0;
      out_data_s[slice_lsb(SLICE_CUR, Pra_Width) +: Pra_Width] = data_r;
      for (int k = SLICE_FIRST_RAM; k < Pra_Rows; k++) begin
         if (LW'(k) <= line_q_r) begin
            out_data_s[slice_lsb(k, Pra_Width) +: Pra_Width] = ram_rd_s[k-1];
         end else begin
            out_data_s[slice_lsb(k, Pra_Width) +: Pra_Width] = '0;
         end
      end
   end

   assign out_vs       = vs_r;
   assign out_hs       = hs_r;
   assign out_en       = out_en_r;
   assign out_full     = out_full_r;
   assign err_overflow = err_r;
   assign out_data     = out_data_s;

endmodule

// File: tb/tb_image_line_window.sv
// Self-checking bench for image_line_window: directed vector table, corner sequences,
// and randomized frames compared against a per-column history model.
module tb_image_line_window;
   import image_stream_pkg::*;

   localparam int W  = 8;
   localparam int R  = 3;
   localparam int MC = 16;

   logic           clk = 1'b0;
   logic           rst, in_vs, in_hs, in_en;
   pixel_t         in_data;
   logic           out_vs, out_hs, out_en, out_full, err_overflow;
   logic [R*W-1:0] out_data;

   image_line_window #(.Pra_Width(W), .Pra_Rows(R), .Pra_Max_Cols(MC)) dut (
      .clk(clk), .rst(rst), .in_vs(in_vs), .in_hs(in_hs), .in_en(in_en),
      .in_data(in_data), .out_vs(out_vs), .out_hs(out_hs), .out_en(out_en),
      .out_data(out_data), .out_full(out_full), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Reference model: spec rules on plain ints; each column keeps its own history,
   // newest first, so "k lines above" is simply the k-th older entry of that column.
   int     m_vs_p, m_hs_p, m_en_p, m_sync, m_col, m_line, m_err;
   pixel_t hist [MC][$];
   logic   e_vs, e_hs, e_en, e_full, e_err;
   pixel_t e_sl [R];
   bit     e_kn [R];

   task automatic model(input bit r, input bit v, input bit h, input bit e, input pixel_t d);
      bit vr, hr, sy, acc, ovf;
      int col, line;
      if (r) begin
         m_vs_p = 0; m_hs_p = 0; m_en_p = 0; m_sync = 0; m_col = 0; m_line = 0; m_err = 0;
         e_vs = 0; e_hs = 0; e_en = 0; e_full = 0; e_err = 0;
         for (int k = 0; k < R; k++) begin e_sl[k] = 8'h00; e_kn[k] = 1'b1; end
         return;
      end
      vr   = v && (m_vs_p == 0);
      hr   = h && (m_hs_p == 0);
      sy   = (m_sync != 0) || vr;
      col  = (vr || hr) ? 0 : m_col;
      line = vr ? 0 : m_line;
      acc  = e && sy && (col < MC);
      ovf  = e && sy && (col >= MC);
      e_vs = v; e_hs = h; e_en = acc;
      e_full = acc && (line == R-1);
      e_err  = vr ? 1'b0 : ((m_err != 0) || ovf);
      if (acc) begin
         e_sl[0] = d; e_kn[0] = 1'b1;
         for (int k = 1; k < R; k++) begin
            if (k > line) begin e_sl[k] = 8'h00; e_kn[k] = 1'b1; end
            else if (hist[col].size() >= k) begin e_sl[k] = hist[col][k-1]; e_kn[k] = 1'b1; end
            else e_kn[k] = 1'b0;
         end
         hist[col].push_front(d);
         if (hist[col].size() > R) void'(hist[col].pop_back());
         col++;
      end
      if (!vr && (m_en_p != 0) && !e && (m_sync != 0) && (line < R-1)) line++;
      m_sync = sy ? 1 : 0; m_err = e_err ? 1 : 0; m_col = col; m_line = line;
      m_vs_p = v; m_hs_p = h; m_en_p = e;
   endtask

   task automatic step(input bit r, input bit v, input bit h, input bit e, input pixel_t d);
      rst = r; in_vs = v; in_hs = h; in_en = e; in_data = d;
      model(r, v, h, e, d);
      @(posedge clk); #1;
      chk("out_vs", 32'(out_vs), 32'(e_vs));
      chk("out_hs", 32'(out_hs), 32'(e_hs));
      chk("out_en", 32'(out_en), 32'(e_en));
      chk("out_full", 32'(out_full), 32'(e_full));
      chk("err_overflow", 32'(err_overflow), 32'(e_err));
      if (e_en || r)
         for (int k = 0; k < R; k++)
            if (e_kn[k]) chk($sformatf("slice%0d", k), 32'(out_data[k*W +: W]), 32'(e_sl[k]));
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // One line: hs gap, hs pulse, n pixels valued line*16+col, then en falls.
   task automatic send_line(input int l, input int n);
      idle(3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int c = 0; c < n; c++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, pixel_t'(l*16 + c));
         if (l == 0 && c == 3) chk("l0c3_data", 32'(out_data), 32'h000003);
         if (l == 1 && c == 3) chk("l1c3_data", 32'(out_data), 32'h000313);
         if (l == 2 && c == 5) begin
            chk("l2c5_data", 32'(out_data), 32'h051525);
            chk("l2c5_full", 32'(out_full), 32'd1);
         end
         if (n > MC) begin
            chk("ovf_en", 32'(out_en), 32'(c < MC));
            if (c >= MC) chk("ovf_err", 32'(err_overflow), 32'd1);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   typedef struct {
      bit r, v, h, e; pixel_t d;
      bit xvs, xhs, xen, xfull, xerr; logic [23:0] xdata;
   } vec_t;
   vec_t tv [12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, gating before first vs, first frame start and the first two lines.
      tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
      tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00000A};
      tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h00000B};
      tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h1A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000A1A};
      tv[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h1B, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000B1B};
      tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};

      for (int i = 0; i < 12; i++) begin
         rst = tv[i].r; in_vs = tv[i].v; in_hs = tv[i].h; in_en = tv[i].e; in_data = tv[i].d;
         model(tv[i].r, tv[i].v, tv[i].h, tv[i].e, tv[i].d);
         @(posedge clk); #1;
         chk($sformatf("tv%0d_vs", i), 32'(out_vs), 32'(tv[i].xvs));
         chk($sformatf("tv%0d_hs", i), 32'(out_hs), 32'(tv[i].xhs));
         chk($sformatf("tv%0d_en", i), 32'(out_en), 32'(tv[i].xen));
         chk($sformatf("tv%0d_full", i), 32'(out_full), 32'(tv[i].xfull));
         chk($sformatf("tv%0d_err", i), 32'(err_overflow), 32'(tv[i].xerr));
         if (tv[i].xen || tv[i].r) chk($sformatf("tv%0d_data", i), 32'(out_data), 32'(tv[i].xdata));
      end

      // Four-line frame of 8 pixels each.
      idle(2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int l = 0; l < 4; l++) send_line(l, 8);

      // Over-long line, sticky flag, cleared by the next frame start.
      idle(2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      send_line(0, 18);
      idle(2);
      chk("ovf_sticky", 32'(err_overflow), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("ovf_clear", 32'(err_overflow), 32'd0);

      // Reset in the middle of line 2; rest of that frame must be dropped.
      idle(2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      send_line(0, 8);
      send_line(1, 8);
      idle(3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b1, pixel_t'(32 + c));
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h23);
      chk("rst_en", 32'(out_en), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_full", 32'(out_full), 32'd0);
      chk("rst_err", 32'(err_overflow), 32'd0);
      for (int c = 4; c < 8; c++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, pixel_t'(32 + c));
         chk("postrst_en", 32'(out_en), 32'd0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      send_line(3, 8);
      idle(2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("newframe_en", 32'(out_en), 32'd1);
      chk("newframe_data", 32'(out_data), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // vs rise, hs rise and a pixel on one cycle: column 0 of line 0, upper slices masked.
      idle(2);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
      chk("vshs_en", 32'(out_en), 32'd1);
      chk("vshs_data", 32'(out_data), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      idle(2);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
      chk("vshs_mask", 32'(out_data), 32'h00005A);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Randomized frames: variable line counts and lengths, occasional resets.
      for (int f = 0; f < 8; f++) begin
         idle($urandom_range(1, 3));
         repeat ($urandom_range(1, 3)) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         for (int l = 0; l < $urandom_range(1, 6); l++) begin
            idle($urandom_range(1, 4));
            repeat ($urandom_range(1, 2)) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            for (int c = 0; c < $urandom_range(1, 20); c++)
               step($urandom_range(0, 199) == 0, 1'b0, 1'b0, 1'b1, pixel_t'($urandom));
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
